// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use and ecall interlocks, data-memory wait hold,
// and the ecall-triggered drain/halt sequence with a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_is_ecall,
    input  logic        id_halt_cond,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic        mem_mem_read,
    input  logic        mem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        pipe_hold,
    output logic        dmem_valid,
    output logic        is_halted,
    output logic [15:0] stall_cycles
);

    localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
    localparam logic [CW-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? CW'(DRAIN_CYCLES - 1) : '0;

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

    state_t        state, next_state, eff_state;
    logic [CW-1:0] drain_cnt;
    logic          load_use, ecall_haz, mem_stall, halt_go;

    // During the reset cycle the combinational outputs follow RUN rules.
    always_comb begin
        eff_state = reset ? RUN : state;
        load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        ecall_haz = id_is_ecall &&
                    ((ex_reg_write && (ex_rd == 5'd17)) || (mem_mem_read && (mem_rd == 5'd17)));
        mem_stall = (eff_state != HALTED) && mem_req && !dmem_ready;
        halt_go   = id_is_ecall && id_halt_cond && !ecall_haz && !mem_stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            drain_cnt    <= '0;
            stall_cycles <= '0;
            is_halted    <= 1'b0;
        end else begin
            state     <= next_state;
            is_halted <= (next_state == HALTED);
            if (state != DRAIN && next_state == DRAIN)
                drain_cnt <= DRAIN_LOAD;
            else if (state == DRAIN && !mem_stall && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;
            if ((state == RUN || state == MEM_WAIT) && !pc_write && stall_cycles != '1)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

    // The MEM_WAIT ready cycle takes the same exits as RUN, including drain entry.
    always_comb begin
        next_state = state;
        case (state)
            RUN, MEM_WAIT: begin
                if (mem_stall)    next_state = MEM_WAIT;
                else if (halt_go) next_state = DRAIN;
                else              next_state = RUN;
            end
            DRAIN:   if (!mem_stall && drain_cnt == '0) next_state = HALTED;
            HALTED:  next_state = HALTED;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        dmem_valid   = 1'b0;
        if (eff_state == HALTED) begin
            id_ex_bubble = 1'b1;
        end else begin
            dmem_valid = mem_req;
            if (mem_stall) begin
                pipe_hold = 1'b1;
            end else if (eff_state == DRAIN) begin
                id_ex_bubble = 1'b1;
            end else if (load_use || ecall_haz) begin
                id_ex_bubble = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard/halt/reset scenarios followed by
// random stimulus, every cycle checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
    logic        id_use_rs1, id_use_rs2, id_is_ecall, id_halt_cond;
    logic        ex_mem_read, ex_reg_write, mem_mem_read, mem_req, dmem_ready;
    logic        pc_write, if_id_write, id_ex_bubble, pipe_hold, dmem_valid, is_halted;
    logic [15:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    // Model: halted flag, draining flag with remaining non-held drain cycles, stall count.
    bit m_halted, m_draining;
    int m_left, m_stalls;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_ecall(id_is_ecall), .id_halt_cond(id_halt_cond),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .pipe_hold(pipe_hold), .dmem_valid(dmem_valid), .is_halted(is_halted),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_is_ecall = 1'b0; id_halt_cond = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; mem_mem_read = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    endtask

    function automatic logic [4:0] pick_reg();
        int r = $urandom_range(0, 5);
        return (r == 5) ? 5'd17 : 5'(r);
    endfunction

    // Called with inputs set just after a falling edge; checks, then advances one clock.
    task automatic cycle();
        logic lu, eh, ms, halted_now, e_pc, e_bub, e_hold, e_dv;
        #1;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        eh = id_is_ecall && ((ex_reg_write && ex_rd == 17) || (mem_mem_read && mem_rd == 17));
        halted_now = m_halted && !reset;
        ms = !halted_now && mem_req && !dmem_ready;
        e_pc = 0; e_bub = 0; e_hold = 0; e_dv = 0;
        if (halted_now) e_bub = 1;
        else begin
            e_dv = mem_req;
            if (ms) e_hold = 1;
            else if (m_draining && !reset) e_bub = 1;
            else if (lu || eh) e_bub = 1;
            else e_pc = 1;
        end
        chk("pc_write", 32'(pc_write), 32'(e_pc));
        chk("if_id_write", 32'(if_id_write), 32'(e_pc));
        chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
        chk("pipe_hold", 32'(pipe_hold), 32'(e_hold));
        chk("dmem_valid", 32'(dmem_valid), 32'(e_dv));
        chk("is_halted", 32'(is_halted), 32'(m_halted));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        @(posedge clk);
        if (reset) begin
            m_halted = 0; m_draining = 0; m_left = 0; m_stalls = 0;
        end else if (m_halted) begin
        end else if (m_draining) begin
            if (!ms) begin
                m_left--;
                if (m_left == 0) begin m_draining = 0; m_halted = 1; end
            end
        end else begin
            if (!e_pc && m_stalls < 65535) m_stalls++;
            if (!ms && id_is_ecall && id_halt_cond && !eh) begin
                m_draining = 1; m_left = 3;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; cycle(); reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        m_halted = 0; m_draining = 0; m_left = 0; m_stalls = 0;
        @(posedge clk); @(negedge clk);
        chk("reset_stalls", 32'(stall_cycles), 32'd0);
        chk("reset_halted", 32'(is_halted), 32'd0);
        // Reset cycle with a load-use present: combinational outputs follow RUN rules.
        set_load_use(); cycle();
        chk("reset_lu_stalls", 32'(stall_cycles), 32'd0);

        // Load-use: one stall cycle, then ex_rd=0 variant causes none.
        idle(); set_load_use(); cycle();
        idle(); cycle();
        chk("lu_stall_count", 32'(stall_cycles), 32'd1);
        set_load_use(); ex_rd = 5'd0; id_rs1 = 5'd0; cycle();
        idle(); cycle();
        chk("lu_x0_no_stall", 32'(stall_cycles), 32'd1);

        // Memory wait of 4 cycles with simultaneous load-use.
        do_reset();
        idle(); set_load_use(); mem_req = 1'b1; dmem_ready = 1'b0;
        repeat (4) cycle();
        idle(); mem_req = 1'b1; dmem_ready = 1'b1; cycle();
        chk("memwait_stalls", 32'(stall_cycles), 32'd4);

        // Halt: ecall advances, 3 drain bubbles, then halted and sticky.
        do_reset();
        idle(); id_is_ecall = 1'b1; id_halt_cond = 1'b1; cycle();
        idle(); repeat (3) cycle();
        chk("halt_entry", 32'(is_halted), 32'd1);
        repeat (20) begin
            mem_req = $urandom_range(0, 1); dmem_ready = $urandom_range(0, 1); cycle();
        end
        chk("halt_sticky", 32'(is_halted), 32'd1);

        // Ecall hazard stall, then drain extended by a 2-cycle memory hold.
        do_reset();
        idle(); id_is_ecall = 1'b1; id_halt_cond = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd17; cycle();
        ex_reg_write = 1'b0; ex_rd = 5'd0; cycle();
        chk("ecall_haz_stalls", 32'(stall_cycles), 32'd1);
        idle(); cycle();
        mem_req = 1'b1; dmem_ready = 1'b0; repeat (2) cycle();
        idle(); repeat (2) cycle();
        chk("drain_extended", 32'(is_halted), 32'd1);

        // Reset in MEM_WAIT, then reset while halted.
        do_reset();
        idle(); mem_req = 1'b1; dmem_ready = 1'b0; repeat (2) cycle();
        reset = 1'b1; cycle();
        chk("rst_memwait_stalls", 32'(stall_cycles), 32'd0);
        idle(); cycle();
        chk("rst_memwait_run", 32'(stall_cycles), 32'd0);
        id_is_ecall = 1'b1; id_halt_cond = 1'b1; cycle();
        idle(); repeat (4) cycle();
        chk("pre_rst_halted", 32'(is_halted), 32'd1);
        reset = 1'b1; cycle();
        chk("rst_halted_flag", 32'(is_halted), 32'd0);
        chk("rst_halted_stalls", 32'(stall_cycles), 32'd0);
        idle(); cycle();

        // Saturation over 70000 continuous load-use cycles.
        do_reset();
        idle(); set_load_use();
        repeat (70000) cycle();
        chk("saturated", 32'(stall_cycles), 32'hFFFF);
        idle(); cycle();

        // Random stimulus with occasional reset so halting does not end exploration.
        do_reset();
        repeat (1500) begin
            reset        = ($urandom_range(0, 49) == 0);
            id_rs1       = pick_reg();
            id_rs2       = pick_reg();
            ex_rd        = pick_reg();
            mem_rd       = pick_reg();
            id_use_rs1   = $urandom_range(0, 1);
            id_use_rs2   = $urandom_range(0, 1);
            id_is_ecall  = ($urandom_range(0, 3) == 0);
            id_halt_cond = ($urandom_range(0, 7) == 0);
            ex_mem_read  = $urandom_range(0, 1);
            ex_reg_write = $urandom_range(0, 1);
            mem_mem_read = $urandom_range(0, 1);
            mem_req      = $urandom_range(0, 1);
            dmem_ready   = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
